// File: rtl/alu_ex_unit.sv
// Execute-stage ALU of the 16-bit pipelined CPU: opcode/funct decode, single-cycle
// arithmetic (including MUL/DIV) and the branch-target adder, all registered.
module alu_ex_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ALUop,
  input  logic [3:0]  funct,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  input  logic [15:0] SE,
  input  logic [7:0]  PC_in,
  output logic [3:0]  operation,
  output logic [15:0] result,
  output logic [15:0] remainder,
  output logic        o,
  output logic [7:0]  BL_result
);

  // There is no valid/ready handshake: a new operation is accepted on every rising
  // edge and its outputs are visible after that same edge.

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_NOP = 4'b1110;
  localparam logic [3:0] OP_MOV = 4'b1111;

  logic [3:0]         op_d;
  logic [15:0]        res_d;
  logic [15:0]        rem_d;
  logic               ovf_d;

  logic [15:0]        sum;
  logic [15:0]        diff;
  logic signed [31:0] prod;
  logic signed [15:0] dividend;
  logic signed [15:0] divisor;
  logic signed [15:0] quo;
  logic signed [15:0] rem;
  logic [3:0]         amt;
  logic [31:0]        rol_w;
  logic [31:0]        ror_w;
  logic               se_unused;

  assign se_unused = ^SE[15:8];

  always_comb begin
    op_d = OP_NOP;
    case (ALUop)
      2'b00: op_d = OP_ADD;
      2'b01: op_d = OP_SUB;
      2'b11: op_d = OP_MOV;
      default: begin
        case (funct)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV,
          OP_SLL, OP_SRL, OP_ROL, OP_ROR: op_d = funct;
          default: op_d = OP_NOP;
        endcase
      end
    endcase
  end

  assign sum  = op1 + op2;
  assign diff = op1 - op2;
  assign prod = $signed({{16{op1[15]}}, op1}) * $signed({{16{op2[15]}}, op2});

  // Divisor is forced to 1 on divide-by-zero so the divider never sees zero;
  // the special cases are overridden below anyway.
  assign dividend = $signed(op1);
  assign divisor  = (op2 == 16'h0000) ? 16'sd1 : $signed(op2);
  assign quo      = dividend / divisor;
  assign rem      = dividend % divisor;

  assign amt   = op2[3:0];
  assign rol_w = {op1, op1} << amt;
  assign ror_w = {op1, op1} >> amt;

  always_comb begin
    res_d = 16'h0000;
    rem_d = 16'h0000;
    ovf_d = 1'b0;
    case (op_d)
      OP_ADD: begin
        res_d = sum;
        ovf_d = (op1[15] == op2[15]) && (sum[15] != op1[15]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (op1[15] != op2[15]) && (diff[15] != op1[15]);
      end
      OP_AND: res_d = op1 & op2;
      OP_OR:  res_d = op1 | op2;
      OP_MUL: begin
        res_d = prod[15:0];
        rem_d = prod[31:16];
        ovf_d = (prod[31:16] != {16{prod[15]}});
      end
      OP_DIV: begin
        if (op2 == 16'h0000) begin
          res_d = 16'h0000;
          rem_d = op1;
          ovf_d = 1'b1;
        end else if (op1 == 16'h8000 && op2 == 16'hFFFF) begin
          res_d = 16'h8000;
          rem_d = 16'h0000;
          ovf_d = 1'b1;
        end else begin
          res_d = quo;
          rem_d = rem;
        end
      end
      OP_SLL: res_d = op1 << amt;
      OP_SRL: res_d = op1 >> amt;
      OP_ROL: res_d = rol_w[31:16];
      OP_ROR: res_d = ror_w[15:0];
      OP_MOV: res_d = op2;
      default: begin
        res_d = 16'h0000;
        rem_d = 16'h0000;
        ovf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      operation <= 4'b0000;
      result    <= 16'h0000;
      remainder <= 16'h0000;
      o         <= 1'b0;
      BL_result <= 8'h00;
    end else begin
      operation <= op_d;
      result    <= res_d;
      remainder <= rem_d;
      o         <= ovf_d;
      BL_result <= PC_in + SE[7:0];
    end
  end

endmodule

// File: tb/tb_alu_ex_unit.sv
// Directed bench for alu_ex_unit: hand-computed vectors checked with immediate
// assertions one edge after each input set is applied.
module tb_alu_ex_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  ALUop;
  logic [3:0]  funct;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [15:0] SE;
  logic [7:0]  PC_in;
  logic [3:0]  operation;
  logic [15:0] result;
  logic [15:0] remainder;
  logic        o;
  logic [7:0]  BL_result;

  int total = 0;
  int bad   = 0;

  alu_ex_unit dut (
    .clk(clk), .reset(reset), .ALUop(ALUop), .funct(funct),
    .op1(op1), .op2(op2), .SE(SE), .PC_in(PC_in),
    .operation(operation), .result(result), .remainder(remainder),
    .o(o), .BL_result(BL_result)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive one input set, then sample #1 after the capturing edge
  task automatic step(input logic [1:0] a, input logic [3:0] f, input logic [15:0] x,
                      input logic [15:0] y, input logic [15:0] se, input logic [7:0] pc);
    ALUop = a; funct = f; op1 = x; op2 = y; SE = se; PC_in = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_op, input logic [15:0] e_res,
                         input logic [15:0] e_rem, input logic e_o);
    chk({tag, ".op"},  {12'h000, operation}, {12'h000, e_op});
    chk({tag, ".res"}, result, e_res);
    chk({tag, ".rem"}, remainder, e_rem);
    chk({tag, ".o"},   {15'h0000, o}, {15'h0000, e_o});
  endtask

  initial begin
    reset = 1'b1;
    ALUop = 2'(  $urandom_range(0, 3));
    funct = 4'(  $urandom_range(0, 15));
    op1   = 16'($urandom_range(0, 65535));
    op2   = 16'($urandom_range(0, 65535));
    SE    = 16'($urandom_range(0, 65535));
    PC_in = 8'(  $urandom_range(0, 255));
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'h0, 16'h0000, 16'h0000, 1'b0);
    chk("reset.bl", {8'h00, BL_result}, 16'h0000);

    reset = 1'b0;
    step(2'b00, 4'h0, 16'h0003, 16'h0004, 16'h0000, 8'h00);
    chk_all("add_first", 4'h0, 16'h0007, 16'h0000, 1'b0);

    step(2'b10, 4'h0, 16'h7FFF, 16'h0001, 16'h0000, 8'h00);
    chk_all("add_ovf", 4'h0, 16'h8000, 16'h0000, 1'b1);
    step(2'b01, 4'h3, 16'h8000, 16'h0001, 16'h0000, 8'h00);
    chk_all("sub_ovf", 4'h1, 16'h7FFF, 16'h0000, 1'b1);
    step(2'b01, 4'h0, 16'h0005, 16'h0005, 16'h0000, 8'h00);
    chk_all("sub_zero", 4'h1, 16'h0000, 16'h0000, 1'b0);

    step(2'b10, 4'h2, 16'hF0F0, 16'h3C3C, 16'h0000, 8'h00);
    chk_all("and", 4'h2, 16'h3030, 16'h0000, 1'b0);
    step(2'b10, 4'h3, 16'hF0F0, 16'h3C3C, 16'h0000, 8'h00);
    chk_all("or", 4'h3, 16'hFCFC, 16'h0000, 1'b0);

    step(2'b10, 4'h4, 16'h0100, 16'h0100, 16'h0000, 8'h00);
    chk_all("mul_ovf", 4'h4, 16'h0000, 16'h0001, 1'b1);
    step(2'b10, 4'h4, 16'hFFFE, 16'h0003, 16'h0000, 8'h00);
    chk_all("mul_neg", 4'h4, 16'hFFFA, 16'hFFFF, 1'b0);

    step(2'b10, 4'h5, 16'hFFF9, 16'h0002, 16'h0000, 8'h00);
    chk_all("div_neg", 4'h5, 16'hFFFD, 16'hFFFF, 1'b0);
    step(2'b10, 4'h5, 16'h0009, 16'h0000, 16'h0000, 8'h00);
    chk_all("div_zero", 4'h5, 16'h0000, 16'h0009, 1'b1);
    step(2'b10, 4'h5, 16'h8000, 16'hFFFF, 16'h0000, 8'h00);
    chk_all("div_min", 4'h5, 16'h8000, 16'h0000, 1'b1);

    step(2'b10, 4'h8, 16'h8001, 16'h0001, 16'h0000, 8'h00);
    chk_all("sll", 4'h8, 16'h0002, 16'h0000, 1'b0);
    step(2'b10, 4'h9, 16'h8001, 16'h0001, 16'h0000, 8'h00);
    chk_all("srl", 4'h9, 16'h4000, 16'h0000, 1'b0);
    step(2'b10, 4'hA, 16'h8001, 16'h0001, 16'h0000, 8'h00);
    chk_all("rol", 4'hA, 16'h0003, 16'h0000, 1'b0);
    step(2'b10, 4'hB, 16'h0001, 16'h0014, 16'h0000, 8'h00);
    chk_all("ror", 4'hB, 16'h1000, 16'h0000, 1'b0);
    step(2'b10, 4'h7, 16'h1234, 16'h5678, 16'h0000, 8'h00);
    chk_all("nop", 4'hE, 16'h0000, 16'h0000, 1'b0);
    step(2'b11, 4'h4, 16'h1111, 16'hBEEF, 16'h0000, 8'h00);
    chk_all("mov", 4'hF, 16'hBEEF, 16'h0000, 1'b0);

    // back-to-back branch targets; the second must not show before its edge
    step(2'b00, 4'h0, 16'h0000, 16'h0000, 16'hFFFC, 8'h10);
    chk("bl_first", {8'h00, BL_result}, 16'h000C);
    ALUop = 2'b00; funct = 4'h0; op1 = 16'h0; op2 = 16'h0; SE = 16'h0004; PC_in = 8'hFE;
    #2;
    chk("bl_hold", {8'h00, BL_result}, 16'h000C);
    @(posedge clk);
    #1;
    chk("bl_wrap", {8'h00, BL_result}, 16'h0002);

    // reset mid-stream discards the operation sampled at that edge
    reset = 1'b1;
    step(2'b00, 4'h0, 16'h7FFF, 16'h0001, 16'h0010, 8'h20);
    chk_all("reset_mid", 4'h0, 16'h0000, 16'h0000, 1'b0);
    chk("reset_mid.bl", {8'h00, BL_result}, 16'h0000);
    reset = 1'b0;
    step(2'b01, 4'h0, 16'h0009, 16'h0002, 16'h0001, 8'h01);
    chk_all("after_reset", 4'h1, 16'h0007, 16'h0000, 1'b0);
    chk("after_reset.bl", {8'h00, BL_result}, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
